// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: lets NREQ byte-stream requesters share one UART transmitter.
//
// Arbitration is round-robin with a packet lock. A grant is held until one of three things happens:
// the requester's LAST byte goes out, MAX_PKT bytes have gone out, or the granted requester keeps
// VALID low for IDLE_TO cycles while the arbiter is waiting for its next byte.
//
// Each byte goes through the same handshake. SEND pulses UART_TX_SEND for one cycle. WAIT_LO waits
// for UART_TX_READY to fall, giving up after ACK_TO cycles. WAIT_HI waits for UART_TX_READY to rise.
// This way no byte is sent twice or dropped.
//
// Optional feature macro: UART_ARB_TAG_EN. When it is defined, every new grant first sends the
// header byte {5'b10100, g[2:0]} (state TAG). The header does not count toward MAX_PKT.
//
// Ports:
//   CLK, RST       clock; synchronous active-high reset
//   REQ_DAT        NREQ*8  per-requester byte, requester i at [8*i+7:8*i]
//   REQ_VALID      NREQ    byte available
//   REQ_LAST       NREQ    byte ends its packet
//   REQ_READY      NREQ    byte accepted this cycle (granted requester only)
//   GRANT          NREQ    one-hot current owner, 0 when idle
//   UART_TX_DAT    8       byte to the transmitter, stable from SEND until WAIT_HI exits
//   UART_TX_SEND   1       one-cycle send strobe
//   UART_TX_READY  1       transmitter idle
//   BUSY           1       arbiter not in IDLE
module uart_tx_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned MAX_PKT = 16,
  parameter int unsigned IDLE_TO = 1024,
  parameter int unsigned ACK_TO  = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREQ*8-1:0] REQ_DAT,
  input  logic [NREQ-1:0]   REQ_VALID,
  input  logic [NREQ-1:0]   REQ_LAST,
  output logic [NREQ-1:0]   REQ_READY,
  output logic [NREQ-1:0]   GRANT,
  output logic [7:0]        UART_TX_DAT,
  output logic              UART_TX_SEND,
  input  logic              UART_TX_READY,
  output logic              BUSY
);

`ifdef UART_ARB_TAG_EN
  typedef enum logic [2:0] {StIdle, StTag, StLoad, StSend, StWaitLo, StWaitHi} state_e;
`else
  typedef enum logic [2:0] {StIdle, StLoad, StSend, StWaitLo, StWaitHi} state_e;
`endif

  // One timer serves both the LOAD idle timeout and the WAIT_LO ack timeout.
  localparam int unsigned TmrMax = (IDLE_TO > ACK_TO) ? IDLE_TO : ACK_TO;
  localparam int unsigned TmrW   = $clog2(TmrMax + 1);
  localparam logic [NREQ-1:0] GrantOne = {{(NREQ-1){1'b0}}, 1'b1};
  localparam logic [2:0]      LastIdx  = 3'(NREQ - 1);
  localparam logic [7:0]      MaxCnt   = 8'(MAX_PKT);

  state_e            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [2:0]        gidx_q, gidx_d;
  logic [2:0]        rr_q, rr_d;
  logic [7:0]        count_q, count_d;
  logic              last_q, last_d;
  logic [7:0]        dat_q, dat_d;
  logic [TmrW-1:0]   timer_q, timer_d;
`ifdef UART_ARB_TAG_EN
  logic              tag_q, tag_d;
`endif

  logic [7:0]        valid_pad;
  logic              arb_found;
  logic [2:0]        arb_idx;
  logic              valid_g;
  logic              last_g;
  logic [7:0]        dat_g;
  logic [2:0]        rr_next;
  logic [NREQ-1:0]   req_ready;

  // Offset k from base, wrapped into 0..NREQ-1. Both inputs are already < NREQ.
  function automatic logic [2:0] wrap_idx(logic [2:0] base, int unsigned k);
    int unsigned s;
    s = int'(base) + k;
    if (s >= NREQ) s -= NREQ;
    return 3'(s);
  endfunction

  // Pad VALID to 8 bits so a 3-bit index always selects within range.
  assign valid_pad = 8'(REQ_VALID);
  assign rr_next   = (gidx_q == LastIdx) ? 3'd0 : gidx_q + 3'd1;

  // Pick the first valid requester at or after the round-robin pointer.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = 3'd0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!arb_found && valid_pad[wrap_idx(rr_q, k)]) begin
        arb_found = 1'b1;
        arb_idx   = wrap_idx(rr_q, k);
      end
    end
  end

  always_comb begin
    dat_g  = 8'h00;
    last_g = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        dat_g  = REQ_DAT[8*i +: 8];
        last_g = REQ_LAST[i];
      end
    end
  end

  assign valid_g = |(REQ_VALID & grant_q);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    rr_d      = rr_q;
    count_d   = count_q;
    last_d    = last_q;
    dat_d     = dat_q;
    timer_d   = timer_q;
`ifdef UART_ARB_TAG_EN
    tag_d     = tag_q;
`endif
    req_ready = '0;

    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        if (arb_found) begin
          grant_d = GrantOne << arb_idx;
          gidx_d  = arb_idx;
`ifdef UART_ARB_TAG_EN
          state_d = StTag;
`else
          state_d = StLoad;
`endif
        end
      end
`ifdef UART_ARB_TAG_EN
      StTag: begin
        if (UART_TX_READY) begin
          dat_d   = {5'b10100, gidx_q};
          tag_d   = 1'b1;
          state_d = StSend;
        end
      end
`endif
      StLoad: begin
        if (valid_g) begin
          timer_d = '0;
          if (UART_TX_READY) begin
            req_ready = grant_q;
            dat_d     = dat_g;
            last_d    = last_g;
            count_d   = (count_q == MaxCnt) ? count_q : count_q + 8'd1;
            state_d   = StSend;
          end
        end else if (timer_q == TmrW'(IDLE_TO - 1)) begin
          // A stalled owner gives up its turn just as if its packet had ended.
          grant_d = '0;
          rr_d    = rr_next;
          count_d = '0;
          timer_d = '0;
          state_d = StIdle;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StSend: begin
        timer_d = '0;
        state_d = StWaitLo;
      end
      StWaitLo: begin
        // If READY never falls, treat the byte as sent rather than risk sending it twice.
        if (!UART_TX_READY || (timer_q == TmrW'(ACK_TO - 1))) begin
          timer_d = '0;
          state_d = StWaitHi;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StWaitHi: begin
        if (UART_TX_READY) begin
`ifdef UART_ARB_TAG_EN
          if (tag_q) begin
            tag_d   = 1'b0;
            state_d = StLoad;
          end else
`endif
          if (last_q || (count_q == MaxCnt)) begin
            grant_d = '0;
            rr_d    = rr_next;
            count_d = '0;
            state_d = StIdle;
          end else begin
            state_d = StLoad;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      grant_q <= '0;
      gidx_q  <= 3'd0;
      rr_q    <= 3'd0;
      count_q <= 8'd0;
      last_q  <= 1'b0;
      dat_q   <= 8'h00;
      timer_q <= '0;
`ifdef UART_ARB_TAG_EN
      tag_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      rr_q    <= rr_d;
      count_q <= count_d;
      last_q  <= last_d;
      dat_q   <= dat_d;
      timer_q <= timer_d;
`ifdef UART_ARB_TAG_EN
      tag_q   <= tag_d;
`endif
    end
  end

  assign REQ_READY    = req_ready;
  assign GRANT        = grant_q;
  assign UART_TX_DAT  = dat_q;
  assign UART_TX_SEND = (state_q == StSend);
  assign BUSY         = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter. Requester drivers and a UART model drive the DUT. The expected byte
// stream (byte plus owner) comes from a packet-level round-robin model, and a monitor compares every
// UART_TX_SEND against it.
module tb_uart_tx_arbiter;
  localparam int NREQ    = 4;
  localparam int MAX_PKT = 4;
  localparam int IDLE_TO = 20;
  localparam int ACK_TO  = 8;
  localparam int BIG     = 1 << 30;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic [NREQ*8-1:0] REQ_DAT;
  logic [NREQ-1:0]   REQ_VALID;
  logic [NREQ-1:0]   REQ_LAST;
  logic [NREQ-1:0]   REQ_READY;
  logic [NREQ-1:0]   GRANT;
  logic [7:0]        UART_TX_DAT;
  logic              UART_TX_SEND;
  logic              UART_TX_READY;
  logic              BUSY;

  uart_tx_arbiter #(
    .NREQ(NREQ), .MAX_PKT(MAX_PKT), .IDLE_TO(IDLE_TO), .ACK_TO(ACK_TO)
  ) dut (
    .CLK(CLK), .RST(RST), .REQ_DAT(REQ_DAT), .REQ_VALID(REQ_VALID), .REQ_LAST(REQ_LAST),
    .REQ_READY(REQ_READY), .GRANT(GRANT), .UART_TX_DAT(UART_TX_DAT),
    .UART_TX_SEND(UART_TX_SEND), .UART_TX_READY(UART_TX_READY), .BUSY(BUSY)
  );

  initial forever #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0] dat;
    logic [7:0] owner;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mem [NREQ][256];
  bit         lst [NREQ][256];
  int         wr [NREQ];
  int         rd [NREQ];
  int         m_rd [NREQ];
  int         stop_at [NREQ];
  int         m_rr;
  int         vectors;
  int         miscompares;
  int         cyc;
  bit         u_armed;
  int         u_cnt;
  int         u_busy;
  bit         deaf;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic load_byte(input int r, input logic [7:0] d, input bit l);
    mem[r][wr[r] % 256] = d;
    lst[r][wr[r] % 256] = l;
    wr[r]++;
  endtask

  task automatic push_exp(input logic [7:0] d, input int owner);
    exp_t e;
    e.dat   = d;
    e.owner = 8'(owner);
    exp_q.push_back(e);
  endtask

  task automatic push_hdr(input int owner);
`ifdef UART_ARB_TAG_EN
    push_exp(8'hA0 | 8'(owner), owner);
`else
    if (owner < 0) push_exp(8'h00, 0);
`endif
  endtask

  // Packet-level round robin: first requester at or after the pointer that has pending bytes gets
  // the transmitter until LAST or MAX_PKT bytes; the pointer then moves past it.
  task automatic run_model();
    int pick;
    int n;
    bit done;
    forever begin
      pick = -1;
      for (int k = 0; k < NREQ; k++) begin
        if (pick < 0 && m_rd[(m_rr + k) % NREQ] < wr[(m_rr + k) % NREQ]) pick = (m_rr + k) % NREQ;
      end
      if (pick < 0) break;
      push_hdr(pick);
      n = 0;
      done = 0;
      while (!done) begin
        push_exp(mem[pick][m_rd[pick] % 256], pick);
        done = lst[pick][m_rd[pick] % 256];
        m_rd[pick]++;
        n++;
        if (n == MAX_PKT || m_rd[pick] == wr[pick]) done = 1;
      end
      m_rr = (pick + 1) % NREQ;
    end
  endtask

  function automatic bit all_sent();
    for (int r = 0; r < NREQ; r++) if (rd[r] != wr[r]) return 0;
    return 1;
  endfunction

  task automatic drain(input string name);
    int n;
    n = 0;
    while (n < 4000 && !(exp_q.size() == 0 && BUSY == 1'b0 && all_sent())) begin
      @(negedge CLK);
      n++;
    end
    check({name, " drain"}, 32'(n < 4000), 32'd1);
    check({name, " grant idle"}, 32'(GRANT), 32'd0);
  endtask

  // Requester drivers and UART model: sample at negedge, update just after posedge.
  initial begin
    logic [NREQ-1:0] xfer;
    logic            sent;
    REQ_VALID = '0;
    REQ_LAST = '0;
    REQ_DAT = '0;
    UART_TX_READY = 1'b1;
    forever begin
      @(negedge CLK);
      xfer = REQ_VALID & REQ_READY;
      sent = UART_TX_SEND;
      @(posedge CLK);
      #1;
      if (RST) begin
        u_armed = 0;
        u_cnt = 0;
        u_busy = 0;
        deaf = 0;
        UART_TX_READY = 1'b1;
        for (int r = 0; r < NREQ; r++) rd[r] = wr[r];
      end else begin
        for (int r = 0; r < NREQ; r++) if (xfer[r]) rd[r]++;
        if (sent && deaf) begin
          deaf = 0;
        end else if (sent) begin
          u_armed = 1;
          u_cnt = $urandom_range(0, 2);
        end
        if (u_armed) begin
          if (u_cnt == 0) begin
            UART_TX_READY = 1'b0;
            u_busy = $urandom_range(1, 5);
            u_armed = 0;
          end else begin
            u_cnt--;
          end
        end else if (u_busy > 0) begin
          u_busy--;
          if (u_busy == 0) UART_TX_READY = 1'b1;
        end
      end
      for (int r = 0; r < NREQ; r++) begin
        REQ_VALID[r]      = (rd[r] < wr[r]) && (rd[r] < stop_at[r]);
        REQ_DAT[8*r +: 8] = mem[r][rd[r] % 256];
        REQ_LAST[r]       = lst[r][rd[r] % 256];
      end
    end
  end

  // Monitor: every SEND is checked against the head of the expected queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        if (REQ_READY != '0) begin
          check("ready only for granted valid", 32'(REQ_READY & ~(GRANT & REQ_VALID)), 32'd0);
        end
        if (UART_TX_SEND) begin
          check("send while uart busy", {30'd0, u_armed, ~UART_TX_READY}, 32'd0);
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected send: got dat %h grant %b, want no send", UART_TX_DAT, GRANT);
          end else begin
            e = exp_q.pop_front();
            check("send byte/owner", {16'd0, UART_TX_DAT, 4'd0, GRANT},
                  {16'd0, e.dat, 4'd0, NREQ'(1) << e.owner});
          end
        end
      end
    end
  end

  task automatic check_reset_outputs(input string name);
    check({name, " GRANT"}, 32'(GRANT), 32'd0);
    check({name, " REQ_READY"}, 32'(REQ_READY), 32'd0);
    check({name, " UART_TX_DAT"}, 32'(UART_TX_DAT), 32'd0);
    check({name, " UART_TX_SEND"}, 32'(UART_TX_SEND), 32'd0);
    check({name, " BUSY"}, 32'(BUSY), 32'd0);
  endtask

  task automatic random_scenario(input string name);
    int np;
    int len;
    bit any;
    any = 0;
    for (int r = 0; r < NREQ; r++) begin
      if ($urandom_range(0, 2) != 0 || (r == NREQ - 1 && !any)) begin
        any = 1;
        np = $urandom_range(1, 3);
        for (int p = 0; p < np; p++) begin
          len = $urandom_range(1, 6);
          for (int b = 0; b < len; b++) load_byte(r, 8'($urandom), b == len - 1);
        end
      end
    end
    run_model();
    drain(name);
  endtask

  initial begin
    int t0;
    int n;
    vectors = 0;
    miscompares = 0;
    m_rr = 0;
    deaf = 0;
    for (int r = 0; r < NREQ; r++) begin
      wr[r] = 0;
      rd[r] = 0;
      m_rd[r] = 0;
      stop_at[r] = BIG;
    end
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset");
    RST = 1'b0;
    @(negedge CLK);

    // Req0 and req2 with one-byte packets: grants alternate 0,2,0,2.
    load_byte(0, 8'h01, 1); load_byte(0, 8'h02, 1);
    load_byte(2, 8'h21, 1); load_byte(2, 8'h22, 1);
    run_model();
    drain("rr 0/2");

    load_byte(0, 8'hAA, 1);
    run_model();
    drain("single AA");

    // Packet lock: req1's 3-byte packet goes out before req3.
    load_byte(1, 8'h11, 0); load_byte(1, 8'h22, 0); load_byte(1, 8'h33, 1);
    load_byte(3, 8'h3C, 1);
    run_model();
    drain("packet lock");

    // MAX_PKT split: req0 streams 10 bytes while req1 waits.
    for (int b = 0; b < 10; b++) load_byte(0, 8'(8'h40 + b), b == 9);
    load_byte(1, 8'h99, 1);
    run_model();
    drain("max pkt");

    // Tag/payload: req2 sends 55 (with the header when tagging is enabled).
    load_byte(2, 8'h55, 1);
    run_model();
    drain("req2 55");

    for (int s = 0; s < 6; s++) random_scenario("random");

    // Idle timeout: req0 sends one byte, then holds VALID low mid-packet.
    stop_at[0] = rd[0] + 1;
    load_byte(0, 8'hD0, 0);
    load_byte(0, 8'hD1, 1);
    push_hdr(0);
    push_exp(8'hD0, 0);
    n = 0;
    while (n < 200 && rd[0] < stop_at[0]) begin
      @(negedge CLK);
      n++;
    end
    t0 = cyc;
    while (n < 400 && GRANT != '0) begin
      @(negedge CLK);
      n++;
    end
    check("idle timeout window", 32'((cyc - t0) >= IDLE_TO + 2 && (cyc - t0) <= IDLE_TO + 16), 32'd1);
    check("idle timeout sent count", 32'(exp_q.size()), 32'd0);
    stop_at[0] = BIG;
    push_hdr(0);
    push_exp(8'hD1, 0);
    m_rd[0] = wr[0];
    m_rr = 1;
    drain("idle timeout resume");

    // Ack timeout: the UART ignores one SEND; the arbiter must still move on.
    deaf = 1;
    load_byte(2, 8'h5A, 0); load_byte(2, 8'hC3, 1);
    run_model();
    drain("ack timeout");

    // Reset while waiting for the transmitter to finish.
    load_byte(1, 8'hE1, 1);
    run_model();
    n = 0;
    while (n < 100 && UART_TX_READY) begin
      @(negedge CLK);
      n++;
    end
    check("reach wait_hi", 32'(UART_TX_READY), 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check_reset_outputs("reset in wait_hi");
    exp_q.delete();
    for (int r = 0; r < NREQ; r++) m_rd[r] = wr[r];
    m_rr = 0;
    RST = 1'b0;
    @(negedge CLK);
    random_scenario("after reset");

    check("leftover expected", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
